// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment scan driver: fonts, blank codes, FSM states.
package fnd_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Active-low fonts {dp,g,f,e,d,c,b,a} with the decimal point off
  localparam logic [7:0] FONT_0 = 8'hC0;
  localparam logic [7:0] FONT_1 = 8'hF9;
  localparam logic [7:0] FONT_2 = 8'hA4;
  localparam logic [7:0] FONT_3 = 8'hB0;
  localparam logic [7:0] FONT_4 = 8'h99;
  localparam logic [7:0] FONT_5 = 8'h92;
  localparam logic [7:0] FONT_6 = 8'h82;
  localparam logic [7:0] FONT_7 = 8'hF8;
  localparam logic [7:0] FONT_8 = 8'h80;
  localparam logic [7:0] FONT_9 = 8'h90;
  localparam logic [7:0] FONT_A = 8'h88;
  localparam logic [7:0] FONT_B = 8'h83;
  localparam logic [7:0] FONT_C = 8'hC6;
  localparam logic [7:0] FONT_D = 8'hA1;
  localparam logic [7:0] FONT_E = 8'h86;
  localparam logic [7:0] FONT_F = 8'h8E;

  localparam logic [7:0] FONT_BLANK = 8'hFF;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // One-hot-low anode pattern for a digit index
  function automatic logic [3:0] an_for(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Font lookup; dp is handled by the caller
  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'h0: seg = FONT_0[6:0];
      4'h1: seg = FONT_1[6:0];
      4'h2: seg = FONT_2[6:0];
      4'h3: seg = FONT_3[6:0];
      4'h4: seg = FONT_4[6:0];
      4'h5: seg = FONT_5[6:0];
      4'h6: seg = FONT_6[6:0];
      4'h7: seg = FONT_7[6:0];
      4'h8: seg = FONT_8[6:0];
      4'h9: seg = FONT_9[6:0];
      4'hA: seg = FONT_A[6:0];
      4'hB: seg = FONT_B[6:0];
      4'hC: seg = FONT_C[6:0];
      4'hD: seg = FONT_D[6:0];
      4'hE: seg = FONT_E[6:0];
      4'hF: seg = FONT_F[6:0];
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit 7-segment scan driver with anti-ghosting dead time, leading-zero
// blanking and blinking decimal points. All outputs are registered.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int DEAD_CYCLES = 1000,
  parameter int BLINK_HZ    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  fnd_sel,
  input  logic [15:0] fnd_data,
  input  logic [3:0]  dot_en,
  input  logic        dot_blink,
  input  logic        lz_blank_en,
  output logic [3:0]  fnd_an,
  output logic [7:0]  fnd_font
);

  localparam int HALF   = CLK_FREQ / (2 * BLINK_HZ);
  localparam int HALF_P = (HALF < 1) ? 1 : HALF;
  localparam int BW     = (HALF_P > 1) ? $clog2(HALF_P) : 1;
  localparam int CW     = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF_P - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  state_t        state, state_n;
  logic [1:0]    sel_q;
  logic [1:0]    cur_sel, cur_sel_n;
  logic [1:0]    blank_sel, blank_sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    an_n;
  logic [7:0]    font_n;

  logic [3:0]    digit;
  logic [6:0]    seg;
  logic          lead_blank;
  logic          dp_lit;
  logic [3:0]    show_an;
  logic [7:0]    show_font;

  // Whenever a digit is shown its index equals sel_q, so one decoder suffices
  assign digit = fnd_data[{sel_q, 2'b00} +: 4];

  fnd_font_decoder u_dec (
    .digit (digit),
    .seg   (seg)
  );

  // Leading-zero detection and dot gating for the digit about to be shown
  always_comb begin
    lead_blank = 1'b0;
    case (sel_q)
      2'd3:    lead_blank = (fnd_data[15:12] == 4'h0);
      2'd2:    lead_blank = (fnd_data[15:8]  == 8'h00);
      2'd1:    lead_blank = (fnd_data[15:4]  == 12'h000);
      default: lead_blank = 1'b0;
    endcase
    lead_blank = lead_blank & lz_blank_en;
    dp_lit     = dot_en[sel_q] & (~dot_blink | blink_phase);
    show_an    = an_for(sel_q);
    show_font  = {~dp_lit, lead_blank ? SEG_OFF : seg};
  end

  // Next-state and next-output logic for the BLANK/SHOW scan FSM
  always_comb begin
    state_n     = state;
    cur_sel_n   = cur_sel;
    blank_sel_n = blank_sel;
    cnt_n       = cnt;
    an_n        = AN_OFF;
    font_n      = FONT_BLANK;
    case (state)
      SHOW: begin
        if (sel_q == cur_sel) begin
          an_n   = show_an;
          font_n = show_font;
        end else if (DEAD_CYCLES == 0) begin
          cur_sel_n = sel_q;
          an_n      = show_an;
          font_n    = show_font;
        end else begin
          state_n     = BLANK;
          blank_sel_n = sel_q;
          cnt_n       = '0;
        end
      end
      default: begin
        if (sel_q != blank_sel) begin
          blank_sel_n = sel_q;
          cnt_n       = '0;
        end else if ((DEAD_CYCLES == 0) || (cnt == CNT_LAST)) begin
          state_n   = SHOW;
          cur_sel_n = sel_q;
          an_n      = show_an;
          font_n    = show_font;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  // FSM state, dead-time counter, sampled select and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BLANK;
      sel_q     <= 2'd0;
      cur_sel   <= 2'd0;
      blank_sel <= 2'd0;
      cnt       <= '0;
      fnd_an    <= AN_OFF;
      fnd_font  <= FONT_BLANK;
    end else begin
      state     <= state_n;
      sel_q     <= fnd_sel;
      cur_sel   <= cur_sel_n;
      blank_sel <= blank_sel_n;
      cnt       <= cnt_n;
      fnd_an    <= an_n;
      fnd_font  <= font_n;
    end
  end

  // Free-running blink timebase, independent of the scan FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked
// against a behavioural display model for a DEAD=4 and a DEAD=0 instance.
module tb_fnd_scan_driver;

  localparam int DEAD  = 4;
  localparam int CLK_F = 16;
  localparam int BHZ   = 2;
  localparam int HALF  = CLK_F / (2 * BHZ);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  fnd_sel = 2'd0;
  logic [15:0] fnd_data = 16'h0000;
  logic [3:0]  dot_en = 4'h0;
  logic        dot_blink = 1'b0;
  logic        lz_blank_en = 1'b0;
  logic [3:0]  an4, an0;
  logic [7:0]  font4, font0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit dark;
    int sel;
    int target;
    int wait_n;
  } model_t;

  model_t m4, m0;
  int sq     = 0;
  int edge_n = 0;

  logic [7:0] font_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  fnd_scan_driver #(.CLK_FREQ(CLK_F), .DEAD_CYCLES(DEAD), .BLINK_HZ(BHZ)) u_dut (
    .clk(clk), .rst(rst), .fnd_sel(fnd_sel), .fnd_data(fnd_data), .dot_en(dot_en),
    .dot_blink(dot_blink), .lz_blank_en(lz_blank_en), .fnd_an(an4), .fnd_font(font4)
  );

  fnd_scan_driver #(.CLK_FREQ(CLK_F), .DEAD_CYCLES(0), .BLINK_HZ(BHZ)) u_dut0 (
    .clk(clk), .rst(rst), .fnd_sel(fnd_sel), .fnd_data(fnd_data), .dot_en(dot_en),
    .dot_blink(dot_blink), .lz_blank_en(lz_blank_en), .fnd_an(an0), .fnd_font(font0)
  );

  always #5 clk = ~clk;

  function automatic model_t model_reset(input int dead);
    model_t m;
    m.dark = 1'b1; m.sel = 0; m.target = 0; m.wait_n = dead;
    return m;
  endfunction

  // Display rules: a new select darkens the display for 'dead' edges; a further
  // change while dark restarts the wait; dead==0 switches instantly.
  function automatic model_t model_step(input model_t m, input int s, input int dead);
    model_t r = m;
    if (r.dark) begin
      if (s != r.target) begin
        r.target = s;
        r.wait_n = dead;
      end else begin
        r.wait_n = r.wait_n - 1;
        if (r.wait_n <= 0) begin
          r.dark = 1'b0;
          r.sel  = s;
        end
      end
    end else if (s != r.sel) begin
      if (dead == 0) r.sel = s;
      else begin
        r.dark = 1'b1; r.target = s; r.wait_n = dead;
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] expect_out(input model_t m, input logic [15:0] data,
                                             input logic [3:0] dots, input logic blink,
                                             input logic lz, input bit phase);
    logic [15:0] upper;
    logic [7:0]  f;
    logic [6:0]  s7;
    logic        dp_lit;
    logic [3:0]  an;
    if (m.dark) return 12'hFFF;
    upper  = data >> (4 * m.sel);
    f      = font_tab[upper[3:0]];
    s7     = f[6:0];
    if (lz && (m.sel > 0) && (upper == 16'h0000)) s7 = 7'h7F;
    dp_lit = dots[m.sel] && (!blink || phase);
    an     = ~(4'b0001 << m.sel);
    return {an, ~dp_lit, s7};
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] data,
                               input logic [3:0] dots, input logic blink, input logic lz);
    fnd_sel     = sel;
    fnd_data    = data;
    dot_en      = dots;
    dot_blink   = blink;
    lz_blank_en = lz;
  endtask

  // One clock edge: advance the models with the inputs seen at the edge, then compare
  task automatic tick();
    logic [11:0] e4, e0;
    bit phase;
    @(posedge clk);
    if (rst) begin
      edge_n++;
      m4    = model_step(m4, sq, DEAD);
      m0    = model_step(m0, sq, 0);
      sq    = int'(fnd_sel);
      phase = (((edge_n - 1) / HALF) % 2) == 0;
      e4    = expect_out(m4, fnd_data, dot_en, dot_blink, lz_blank_en, phase);
      e0    = expect_out(m0, fnd_data, dot_en, dot_blink, lz_blank_en, phase);
    end else begin
      e4 = 12'hFFF;
      e0 = 12'hFFF;
    end
    #1;
    checkOutput("cycle_dead4", {an4, font4}, e4);
    checkOutput("cycle_dead0", {an0, font0}, e0);
  endtask

  task automatic reset_dut();
    rst    = 1'b0;
    m4     = model_reset(DEAD);
    m0     = model_reset(0);
    sq     = 0;
    edge_n = 0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] lz_on [4];
    logic [7:0] lz_off [4];
    int zeros;
    int dark_n;
    bit seen;
    lz_on  = '{8'h92, 8'h99, 8'hFF, 8'hFF};
    lz_off = '{8'h92, 8'h99, 8'hC0, 8'hC0};

    // Reset release with digit 0 of 1234 selected
    applyStimulus(2'd0, 16'h1234, 4'h0, 1'b0, 1'b0);
    reset_dut();
    checkOutput("reset_state", {an4, font4}, 12'hFFF);
    repeat (3) tick();
    checkOutput("t1_still_dark", {an4, font4}, 12'hFFF);
    tick();
    checkOutput("t1_first_digit", {an4, font4}, {4'b1110, 8'h99});

    // Switch to digit 1: two edges of latency, then four dark cycles
    applyStimulus(2'd1, 16'h1234, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t2_before_blank", {8'h00, an4}, {8'h00, 4'b1110});
    dark_n = 0;
    repeat (4) begin
      tick();
      if (an4 == 4'b1111) dark_n++;
    end
    checkOutput("t2_dark_count", 12'(dark_n), 12'd4);
    tick();
    checkOutput("t2_digit1", {an4, font4}, {4'b1101, 8'hB0});

    // Change again during BLANK: the newest select wins after a restart
    applyStimulus(2'd2, 16'h1234, 4'h0, 1'b0, 1'b0);
    repeat (3) tick();
    applyStimulus(2'd3, 16'h1234, 4'h0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (an4 != 4'b1111) seen = 1'b1;
    end
    checkOutput("t2_restart_digit3", {an4, font4}, {4'b0111, 8'hF9});

    // Leading-zero blanking sweep, enabled then disabled
    for (int lz = 1; lz >= 0; lz--) begin
      for (int d = 0; d < 4; d++) begin
        applyStimulus(2'(d), 16'h0045, 4'h0, 1'b0, lz[0]);
        repeat (7) tick();
        checkOutput(lz ? "t3_lz_on" : "t3_lz_off", {4'h0, font4}, {4'h0, lz ? lz_on[d] : lz_off[d]});
      end
    end

    // Blinking dot on digit 1: lit exactly half of every 8-cycle window
    applyStimulus(2'd1, 16'h0045, 4'b0010, 1'b1, 1'b0);
    repeat (7) tick();
    zeros = 0;
    repeat (16) begin
      tick();
      if (font4[7] == 1'b0) zeros++;
    end
    checkOutput("t4_blink_duty", 12'(zeros), 12'd8);
    applyStimulus(2'd1, 16'h0045, 4'b0010, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("t4_steady_dp", {11'h0, font4[7]}, 12'h0);
    for (int d = 0; d < 4; d++) begin
      if (d != 1) begin
        applyStimulus(2'(d), 16'h0045, 4'b0010, 1'b0, 1'b0);
        repeat (7) tick();
        checkOutput("t4_other_dp_off", {11'h0, font4[7]}, 12'h1);
      end
    end

    // Zero dead time: 1011 straight to 0111
    applyStimulus(2'd2, 16'h0045, 4'h0, 1'b0, 1'b0);
    repeat (7) tick();
    checkOutput("t5_digit2", {8'h00, an0}, {8'h00, 4'b1011});
    applyStimulus(2'd3, 16'h0045, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("t5_hold", {8'h00, an0}, {8'h00, 4'b1011});
    tick();
    checkOutput("t5_switch", {8'h00, an0}, {8'h00, 4'b0111});

    // Asynchronous reset in the middle of a blank (count at 2)
    applyStimulus(2'd1, 16'h1234, 4'h0, 1'b0, 1'b0);
    repeat (4) tick();
    fnd_sel = 2'd0;
    #1 rst = 1'b0;
    #1;
    checkOutput("t6_async_reset", {an4, font4}, 12'hFFF);
    reset_dut();
    dark_n = 0;
    repeat (3) begin
      tick();
      if (an4 == 4'b1111) dark_n++;
    end
    checkOutput("t6_dark_after", 12'(dark_n), 12'd3);
    tick();
    checkOutput("t6_first_digit", {an4, font4}, {4'b1110, 8'h99});

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) fnd_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) fnd_data = 16'($urandom()) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) dot_en = 4'($urandom());
      if ($urandom_range(0, 15) == 0) dot_blink = 1'($urandom());
      if ($urandom_range(0, 15) == 0) lz_blank_en = 1'($urandom());
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
